bit_timing_rx: RTL and testbench

- CAN bit timing logic directly upstream of the destuffing stage.
- Synchronises the raw RX line and generates the time quantum and the SYNC/TSEG1/TSEG2 bit segments.
- Applies hard synchronisation and resynchronisation on recessive-to-dominant edges.
- Outputs the sampled bit (destuffing `bitin`), a one-clock sample-point pulse (destuffing `activ` source) and a transmit-point pulse for the TX path.

---
 rtl/bit_timing_rx.sv | 187 ++++++++++++++++++
 tb/tb_bit_timing_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_timing_rx.sv
// CAN receive bit timing: synchronises rx, generates SYNC/TSEG1/TSEG2 segments in
// time quanta, applies hard sync and resync, and emits the sample and transmit points.
module bit_timing_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic [5:0] brp,
    input  logic [3:0] tseg1,
    input  logic [2:0] tseg2,
    input  logic [1:0] sjw,
    input  logic       hardsync,
    input  logic       txbit,
    output logic       sampledbit,
    output logic       smplpoint,
    output logic       txpoint
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TSEG1 = 2'd1,
        ST_TSEG2 = 2'd2
    } state_t;

    state_t                   r_state;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_rx_prev;
    logic [5:0]               r_pc;
    logic [4:0]               r_cnt;
    logic [2:0]               r_ext;
    logic [2:0]               r_shrt;
    logic                     r_syncdone;
    logic                     r_sampledbit;
    logic                     r_smplpoint;
    logic                     r_txpoint;

    state_t                   w_state_nxt;
    logic [5:0]               w_pc_nxt;
    logic [4:0]               w_cnt_nxt;
    logic [2:0]               w_ext_nxt;
    logic [2:0]               w_shrt_nxt;
    logic                     w_syncdone_nxt;
    logic                     w_sampled_nxt;
    logic                     w_smpl_nxt;
    logic                     w_tx_nxt;

    logic                     w_rx_s;
    logic                     w_edge;
    logic                     w_tq_en;
    logic [2:0]               w_sjw_e;
    logic                     w_hard;
    logic                     w_resync;
    logic [4:0]               w_phase_err;
    logic [2:0]               w_ext_new;
    logic                     w_seg1_end;
    logic                     w_seg2_end;
    logic [4:0]               w_seg2_rem;
    logic                     w_early;
    logic                     w_sample;
    logic                     w_bit_end;

    assign w_rx_s      = r_sync[SYNC_STAGES-1];
    assign w_edge      = r_rx_prev & ~w_rx_s;
    assign w_tq_en     = (r_pc == brp);
    assign w_sjw_e     = (({1'b0, sjw} < tseg2) ? {1'b0, sjw} : tseg2) + 3'd1;
    assign w_hard      = w_edge & hardsync;
    assign w_resync    = w_edge & ~hardsync & ~r_syncdone & txbit;
    assign w_phase_err = r_cnt + 5'd1;
    assign w_ext_new   = (w_phase_err < {2'b00, w_sjw_e}) ? w_phase_err[2:0] : w_sjw_e;
    assign w_seg1_end  = (r_cnt == ({1'b0, tseg1} + {2'b00, r_ext}));
    // Written as a sum so a shortened phase 2 never underflows the comparison.
    assign w_seg2_end  = ((r_cnt + {2'b00, r_shrt}) >= {2'b00, tseg2});
    assign w_seg2_rem  = {2'b00, tseg2} - r_cnt;
    assign w_early     = (r_state == ST_TSEG2) & w_resync & (w_seg2_rem < {2'b00, w_sjw_e});
    assign w_sample    = ~w_hard & (r_state == ST_TSEG1) & w_tq_en & w_seg1_end;
    assign w_bit_end   = ~w_hard & (r_state == ST_TSEG2) & ~w_early & w_tq_en & w_seg2_end;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_SYNC;
            r_sync       <= '1;
            r_rx_prev    <= 1'b1;
            r_pc         <= 6'd0;
            r_cnt        <= 5'd0;
            r_ext        <= 3'd0;
            r_shrt       <= 3'd0;
            r_syncdone   <= 1'b0;
            r_sampledbit <= 1'b1;
            r_smplpoint  <= 1'b0;
            r_txpoint    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sync       <= {r_sync[SYNC_STAGES-2:0], rx};
            r_rx_prev    <= w_rx_s;
            r_pc         <= w_pc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ext        <= w_ext_nxt;
            r_shrt       <= w_shrt_nxt;
            r_syncdone   <= w_syncdone_nxt;
            r_sampledbit <= w_sampled_nxt;
            r_smplpoint  <= w_smpl_nxt;
            r_txpoint    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = w_tq_en ? 6'd0 : r_pc + 6'd1;
        w_cnt_nxt      = r_cnt;
        w_ext_nxt      = r_ext;
        w_shrt_nxt     = r_shrt;
        w_syncdone_nxt = r_syncdone;
        w_sampled_nxt  = r_sampledbit;
        if (w_hard) begin
            w_state_nxt    = ST_TSEG1;
            w_cnt_nxt      = 5'd0;
            w_pc_nxt       = 6'd0;
            w_ext_nxt      = 3'd0;
            w_shrt_nxt     = 3'd0;
            w_syncdone_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_SYNC: begin
                    if (w_tq_en) begin
                        w_state_nxt = ST_TSEG1;
                        w_cnt_nxt   = 5'd0;
                    end
                end
                ST_TSEG1: begin
                    if (w_resync) begin
                        w_ext_nxt      = w_ext_new;
                        w_syncdone_nxt = 1'b1;
                    end
                    if (w_tq_en) begin
                        if (w_seg1_end) begin
                            w_sampled_nxt = w_rx_s;
                            w_state_nxt   = ST_TSEG2;
                            w_cnt_nxt     = 5'd0;
                            w_ext_nxt     = 3'd0;
                        end else begin
                            w_cnt_nxt = r_cnt + 5'd1;
                        end
                    end
                end
                ST_TSEG2: begin
                    // An edge too close to the bit end becomes the next SYNC_SEG.
                    if (w_early) begin
                        w_state_nxt    = ST_TSEG1;
                        w_cnt_nxt      = 5'd0;
                        w_pc_nxt       = 6'd0;
                        w_shrt_nxt     = 3'd0;
                        w_syncdone_nxt = 1'b1;
                    end else begin
                        if (w_resync) begin
                            w_shrt_nxt     = w_sjw_e;
                            w_syncdone_nxt = 1'b1;
                        end
                        if (w_tq_en) begin
                            if (w_seg2_end) begin
                                w_state_nxt    = ST_SYNC;
                                w_shrt_nxt     = 3'd0;
                                w_syncdone_nxt = 1'b0;
                            end else begin
                                w_cnt_nxt = r_cnt + 5'd1;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_SYNC;
                    w_cnt_nxt   = 5'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_smpl_nxt = w_sample;
        w_tx_nxt   = w_early | w_bit_end;
    end

    assign sampledbit = r_sampledbit;
    assign smplpoint  = r_smplpoint;
    assign txpoint    = r_txpoint;

endmodule

// File: tb/tb_bit_timing_rx.sv
// Directed bench for bit_timing_rx: table of timing configurations plus hand-built
// hard sync, resync, own-dominant and mid-bit reset sequences; pulses sampled on negedge.
module tb_bit_timing_rx;

    logic       clock;
    logic       reset;
    logic       rx;
    logic [5:0] brp;
    logic [3:0] tseg1;
    logic [2:0] tseg2;
    logic [1:0] sjw;
    logic       hardsync;
    logic       txbit;
    logic       sampledbit;
    logic       smplpoint;
    logic       txpoint;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int overlap  = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [5:0] brp;
        logic [3:0] tseg1;
        logic [2:0] tseg2;
        logic [1:0] sjw;
        int         period;
        int         smpl_off;
    } vec_t;

    vec_t vecs[4];

    bit_timing_rx #(.SYNC_STAGES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .brp        (brp),
        .tseg1      (tseg1),
        .tseg2      (tseg2),
        .sjw        (sjw),
        .hardsync   (hardsync),
        .txbit      (txbit),
        .sampledbit (sampledbit),
        .smplpoint  (smplpoint),
        .txpoint    (txpoint)
    );

    // clock / cycle counter / pulse-overlap monitor
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (txpoint && smplpoint) overlap <= overlap + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset(input logic [5:0] b, input logic [3:0] t1,
                               input logic [2:0] t2, input logic [1:0] s, output int rst_cyc);
        @(negedge clock);
        reset = 1'b0; brp = b; tseg1 = t1; tseg2 = t2; sjw = s;
        rx = 1'b1; hardsync = 1'b0; txbit = 1'b1;
        @(negedge clock);
        rst_cyc = cyc;
        reset = 1'b1;
    endtask

    task automatic wait_tx(input string name, output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (txpoint) begin at = cyc; break; end
        end
        if (at < 0) begin
            check({name, "_tx_timeout"}, 0, 1);
            at = cyc;
        end
    endtask

    task automatic wait_smpl(input string name, output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (smplpoint) begin at = cyc; break; end
        end
        if (at < 0) begin
            check({name, "_smpl_timeout"}, 0, 1);
            at = cyc;
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int r, t0, t1, s, s2, t2, s3, t3;
        // period = (tseg1+tseg2+3)*(brp+1); sample offset = (tseg1+2)*(brp+1)
        vecs[0] = '{6'd1, 4'd5,  3'd2, 2'd1, 20,  14};
        vecs[1] = '{6'd0, 4'd1,  3'd1, 2'd0, 5,   3};
        vecs[2] = '{6'd3, 4'd15, 3'd7, 2'd3, 100, 68};
        vecs[3] = '{6'd2, 4'd3,  3'd4, 2'd2, 30,  15};

        reset = 1'b0; rx = 1'b1; hardsync = 1'b0; txbit = 1'b1;
        brp = 6'd1; tseg1 = 4'd5; tseg2 = 3'd2; sjw = 2'd1;
        skip(3);
        check("reset_sampledbit", int'(sampledbit), 1);
        check("reset_smplpoint",  int'(smplpoint),  0);
        check("reset_txpoint",    int'(txpoint),    0);

        // nominal timing table
        for (int v = 0; v < 4; v++) begin
            exp_q.push_back(16'(vecs[v].period));
            exp_q.push_back(16'(vecs[v].smpl_off));
            exp_q.push_back(16'(vecs[v].period));
            apply_reset(vecs[v].brp, vecs[v].tseg1, vecs[v].tseg2, vecs[v].sjw, r);
            wait_tx("nom", t0);
            check($sformatf("nom%0d_first_tx", v), t0 - r, int'(exp_q.pop_front()));
            wait_smpl("nom", s);
            check($sformatf("nom%0d_smpl_off", v), s - t0, int'(exp_q.pop_front()));
            check($sformatf("nom%0d_sampledbit", v), int'(sampledbit), 1);
            wait_tx("nom", t1);
            check($sformatf("nom%0d_period", v), t1 - t0, int'(exp_q.pop_front()));
        end

        // hard sync: rx low first sampled at t+1, rx_s low after t+2, hard sync at t+3, 6 tq later
        apply_reset(6'd1, 4'd5, 3'd2, 2'd1, r);
        wait_tx("hs", t0);
        skip(5);
        t1 = cyc;
        rx = 1'b0; hardsync = 1'b1;
        wait_smpl("hs", s);
        check("hs_smpl_delay", s - t1, 15);
        check("hs_sampledbit", int'(sampledbit), 0);
        wait_tx("hs", t2);
        check("hs_tx_after_smpl", t2 - s, 6);

        // reset for one clock in TSEG1 of the following bit
        rx = 1'b1; hardsync = 1'b0;
        skip(4);
        check("pre_reset_sampledbit", int'(sampledbit), 0);
        reset = 1'b0;
        @(negedge clock);
        r = cyc;
        check("midreset_sampledbit", int'(sampledbit), 1);
        check("midreset_smplpoint",  int'(smplpoint),  0);
        check("midreset_txpoint",    int'(txpoint),    0);
        reset = 1'b1;
        wait_tx("mr", t0);
        check("midreset_first_tx", t0 - r, 20);

        // late edge at TSEG1 cnt=3 lengthens by sjw_e=2 tq; edge in TSEG2 of the same bit is ignored
        apply_reset(6'd1, 4'd5, 3'd2, 2'd1, r);
        wait_tx("late", t0);
        skip(6);
        rx = 1'b0;
        skip(4);
        rx = 1'b1;
        wait_smpl("late", s);
        check("late_smpl_off", s - t0, 18);
        check("late_sampledbit", int'(sampledbit), 1);
        rx = 1'b0;
        wait_tx("late", t1);
        check("late_second_edge_ignored", t1 - s, 6);

        // own dominant bit: no resync
        apply_reset(6'd1, 4'd5, 3'd2, 2'd1, r);
        wait_tx("own", t0);
        txbit = 1'b0;
        skip(6);
        rx = 1'b0;
        wait_smpl("own", s);
        check("own_smpl_off", s - t0, 14);
        check("own_sampledbit", int'(sampledbit), 0);
        txbit = 1'b1;

        // early edge in TSEG2 (tseg2=4, sjw_e=1)
        apply_reset(6'd1, 4'd5, 3'd4, 2'd0, r);
        wait_tx("early", t0);
        wait_smpl("early", s);
        check("early_nom_smpl_off", s - t0, 14);
        skip(6);
        rx = 1'b0;
        wait_tx("early", t1);
        check("early_cnt4_tx", t1 - s, 9);
        wait_smpl("early", s2);
        check("early_cnt4_next_smpl", s2 - t1, 12);
        check("early_cnt4_sampledbit", int'(sampledbit), 0);
        rx = 1'b1;
        wait_tx("early", t2);
        check("early_nom_tseg2", t2 - s2, 10);
        wait_smpl("early", s3);
        rx = 1'b0;
        wait_tx("early", t3);
        check("early_cnt1_shortened", t3 - s3, 8);

        check("pulse_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
